// File: rtl/nfa_pkg.sv
// nfa_pkg: shared class indices, default decoder width and class-index width helper for the NFA engines
package nfa_pkg;
  localparam int N_CLASS_DEF = 64;
  localparam int CLS_SPACE = 0, CLS_COLON = 1, CLS_SEMI = 2, CLS_DIGIT = 3;
  localparam int CLS_A = 4, CLS_B = 5, CLS_C = 6, CLS_D = 7, CLS_E = 8, CLS_F = 9, CLS_G = 10;
  localparam int CLS_H = 11, CLS_I = 12, CLS_J = 13, CLS_K = 14, CLS_L = 15, CLS_M = 16;
  localparam int CLS_N = 17, CLS_O = 18, CLS_P = 19, CLS_Q = 20, CLS_R = 21, CLS_S = 22;
  localparam int CLS_T = 23, CLS_U = 24, CLS_V = 25, CLS_W = 26, CLS_X = 27, CLS_Y = 28;
  localparam int CLS_Z = 29;
  function automatic int cls_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nfa_state_cell.sv
// nfa_state_cell: one chain position; consumes its class when fed, or loops on itself when starred
module nfa_state_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sod,
  input  logic cls,
  input  logic feed,
  input  logic star,
  output logic q
);
  always_ff @(posedge clk)
    q <= (rst || (sod && !en)) ? 1'b0 : en ? (cls & (feed | (star & q & !sod))) : q;
endmodule

// File: rtl/nfa_chain_engine.sv
// nfa_chain_engine: linear class chain NFA with sticky match; NFA_MATCH_OFFSET_EN builds the match byte offset
module nfa_chain_engine
  import nfa_pkg::*;
#(
  parameter int                        N_STATES  = 24,
  parameter int                        N_CLASS   = N_CLASS_DEF,
  parameter int                        CLS_W     = cls_w(N_CLASS),
  parameter logic [N_STATES*CLS_W-1:0] CLASS_SEL = '0,
  parameter logic [N_STATES-1:0]       STAR_MASK = '0,
  parameter bit                        ANCHORED  = 1'b0,
  parameter int                        OFF_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sod,
  input  logic               en,
  input  logic [N_CLASS-1:0] cls_in,
  output logic               match,
  output logic               match_pulse,
  output logic [OFF_W-1:0]   match_offset
);
  logic [N_STATES:0]   feed;
  logic [N_STATES-1:0] q;
  logic                unused_cls;
  assign unused_cls = ^cls_in;
  assign feed[0] = ANCHORED ? (sod & en) : 1'b1;
  // a new packet sees an empty chain, so stale state never feeds forward on sod
  for (genvar i = 0; i < N_STATES; i++) begin : g_st
    assign feed[i+1] = (q[i] & !sod) | (STAR_MASK[i] & feed[i]);
    nfa_state_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .sod  (sod),
      .cls  (cls_in[CLASS_SEL[i*CLS_W +: CLS_W]]),
      .feed (feed[i]),
      .star (STAR_MASK[i]),
      .q    (q[i])
    );
  end
  always_ff @(posedge clk)
    if (rst || sod) begin
      match       <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      match       <= match | feed[N_STATES];
      match_pulse <= !match & feed[N_STATES];
    end
`ifdef NFA_MATCH_OFFSET_EN
  logic [OFF_W-1:0] cnt, last_idx;
  always_ff @(posedge clk)
    if (rst || (sod && !en)) begin
      cnt          <= '0;
      last_idx     <= '0;
      match_offset <= '0;
    end else begin
      if (en) begin
        cnt      <= sod ? OFF_W'(1) : (&cnt ? cnt : cnt + OFF_W'(1));
        last_idx <= sod ? '0 : cnt;
      end
      match_offset <= sod ? '0 : (!match && feed[N_STATES]) ? last_idx : match_offset;
    end
`else
  assign match_offset = '0;
`endif
endmodule

// File: doc/nfa_chain_engine.md
# nfa_chain_engine

Parametrised successor to the per-rule generated NFA engines. It matches one linear PCRE-style chain of character classes, with optional `x*` repetition per state, against the decoded byte stream from the shared character-class decoder. Its outputs are a sticky match flag, a first-match pulse and the byte offset of the match. One instance serves one rule. The payload engine top instantiates it once per rule, with the chain configured entirely through parameters.

## Interface
- `N_STATES`, 24: number of character states in the chain (1..64).
- `N_CLASS`, 64: number of decoded class lines from the decoder.
- `CLS_W`, `$clog2(N_CLASS)`: class index width (derived; do not override).
- `CLASS_SEL`, all zero: packed `N_STATES*CLS_W` bits. Slice i gives the class index consumed by state i.
- `STAR_MASK`, 0: `N_STATES` bits. Bit i makes state i `class*`: it has a self-loop and may be bypassed.
- `ANCHORED`, 0: 1 means the chain may start only on the first byte after `sod`; 0 means it may start on any byte.
- `OFF_W`, 16: width of the byte offset.
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `sod`, in, 1: start-of-data strobe, sampled with `en`.
- `en`, in, 1: a byte is valid on `cls_in` this cycle.
- `cls_in`, in, `N_CLASS`: decoded class hits for the current byte. Case folding is done upstream.
- `match`, out, 1: sticky match, held until `sod` or `rst`.
- `match_pulse`, out, 1: one-cycle pulse on the edge where `match` rises.
- `match_offset`, out, `OFF_W`: index (0-based from `sod`) of the last byte of the first match.

## Operation
- **Feed chain (combinational):**
  - `feed[0]` = `start`.
  - `feed[i+1]` = `q[i] | (STAR_MASK[i] & feed[i])`.
  - `start` = 1 when `ANCHORED`=0. When `ANCHORED`=1, `start` = `sod & en`.
- **State register update:** on an edge with `en`=1, `q[i]` <= `cls_in[CLASS_SEL[i]] & (feed[i] | (STAR_MASK[i] & q[i]))`.
- **`en`=0:** `q` holds.
- **`sod & en`:** the next state is computed with all `q` treated as 0. The byte in that cycle is byte 0 of the new packet.
- **`sod & !en`:** all `q` clear. `match`, `match_pulse` and the offset state clear.
- **Match register:** it is not gated by `en`. On each edge, `match` <= `match | feed[N_STATES]`. A trailing star state therefore counts as satisfied.
- **Byte counter `cnt`:**
  - Set to 1 on `sod & en`.
  - Otherwise increments on `en`, saturating at all ones.
  - `last_idx` <= (`sod` ? 0 : `cnt`) on every `en` edge.
- **First match:** on the edge where `match` rises, `match_offset` <= `last_idx` and `match_pulse` = 1 for one cycle. Later matches in the same packet change nothing.
- **Priority:** `rst` > `sod` > normal update. If `sod` coincides with a pending `feed[N_STATES]` from the previous packet, that match is dropped.
- **Reset values:** all `q`, `match`, `match_pulse`, `match_offset`, `cnt` and `last_idx` = 0.
- **Degenerate chain:** with `ANCHORED`=0 and every state starred, `feed[N_STATES]`=1. `match` asserts on the first edge after reset/`sod` clears, and `match_offset` = 0.

## Timing
- Last byte of the pattern sampled at edge k (`en`=1): `q[N_STATES-1]` is set after edge k.
- `match` and `match_pulse` are visible after edge k+1, regardless of `en` at k+1.
- Fixed latency of 2 edges from the last byte to `match`.
- Throughput: one byte per cycle. `en` gaps are allowed anywhere.
- No combinational path from any input to any output.

## Configuration
- **Macro:** `NFA_MATCH_OFFSET_EN`.
- **Defined:** `cnt`, `last_idx` and the `match_offset` register exist and behave as described above.
- **Undefined:** `cnt`, `last_idx` and the `match_offset` register are not built, and `match_offset` is tied to 0. `match` and `match_pulse` behave identically in both builds.

## Structure
- **Shared package `nfa_pkg`:**
  - Class index constants: `CLS_SPACE` (`\s`), `CLS_COLON`, `CLS_SEMI`, one per case-folded letter, etc.
  - `cls_w(n)` helper.
  - Default `N_CLASS`.
- **Sub-module `nfa_state_cell`:** one state register holding `cls`, `feed`, `star`, `en`, `sod` and `rst`. It is generated `N_STATES` times, and the feed chain is built in a generate loop in the top.

## Test plan
- **Literal chain:** `N_STATES`=3, classes a,b,c, `ANCHORED`=0. Stream `sod`+"xabc" -> `match` rises two edges after 'c', `match_pulse` high for one cycle, `match_offset`=3.
- **Star bypass and repeat:** chain a, `\s`* , c. Check both cases:
  - "ac" -> match, offset 1.
  - "a   c" -> match, offset 4.
  - "a x c" -> no match.
- **Anchored:** `ANCHORED`=1, chain ab.
  - "ab" -> match, offset 1.
  - "xab" -> no match.
  - A new `sod`+"ab" after that -> match, offset 1.
- **`en` gaps:** "abc" with `en` low for 3 cycles between each byte -> match, offset 2. `match` rises exactly one edge after `q[2]` sets, even with `en`=0.
- **`sod` collision:** assert `sod & en` on the edge after 'c' -> `match` stays 0. The new packet starts at index 0.
- **Reset and sticky:** after a match, a second occurrence at offset 9 -> `match_offset` stays at the first value and no second pulse. Pulsing `rst` mid-packet clears all outputs to 0 on the next edge.
